simon_round_controller: RTL and testbench



---
 rtl/simon_pkg.sv | 32 +++
 rtl/simon_timeout_timer.sv | 31 +++
 rtl/simon_round_controller.sv | 146 ++++++++++++++
 tb/tb_simon_round_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says round controller.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_DISP,
    S_WAIT,
    S_CHK,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_DISP = 2'b01;
  localparam logic [1:0] PH_WAIT = 2'b10;
  localparam logic [1:0] PH_CHK  = 2'b11;

  localparam int DEFAULT_MAX_ROUNDS     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 2_000_000;

  // Debug phase code for a state; GEN, WIN and LOSE share the idle code.
  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_DISP:  phase_of = PH_DISP;
      S_WAIT:  phase_of = PH_WAIT;
      S_CHK:   phase_of = PH_CHK;
      default: phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/simon_timeout_timer.sv
// Inactivity counter for the input phase. Counts while run is high,
// returns to zero on clr or whenever run is low.
module simon_timeout_timer #(
  parameter int TIMEOUT_CYCLES = simon_pkg::DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMER_W        = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  // Count idle cycles; any clear or leaving the run window zeroes the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      count <= '0;
    end else if (clr || !run) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/simon_round_controller.sv
// Central Simon Says sequencer: one FSM driving the generator, display,
// input-capture and compare stages, owning the round index, the input
// inactivity timeout and the win/lose result. All outputs are registered
// copies of what the next state decodes to.
module simon_round_controller
  import simon_pkg::*;
#(
  parameter int MAX_ROUNDS     = DEFAULT_MAX_ROUNDS,
  parameter int ROUND_W        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMER_W        = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               press,
  output logic               gen_en,
  input  logic               gen_done,
  output logic               disp_en,
  input  logic               disp_done,
  output logic               wait_en,
  input  logic               wait_done,
  output logic               chk_en,
  input  logic               chk_done,
  input  logic               chk_pass,
  output logic               stage_clr,
  output logic [ROUND_W-1:0] round,
  output logic               win,
  output logic               lose,
  output logic [1:0]         phase
);

  state_t             state, next_state;
  logic [ROUND_W-1:0] next_round;
  logic               start_q;
  logic               start_rise;
  logic               timer_clr, timer_run, timer_expired;
  logic               timeout;

  logic               nxt_gen_en, nxt_disp_en, nxt_wait_en, nxt_chk_en;
  logic               nxt_stage_clr, nxt_win, nxt_lose;
  logic [1:0]         nxt_phase;

  assign start_rise = start & ~start_q;

  // A press in the expiry cycle clears the timer and cancels the loss.
  assign timeout   = (state == S_WAIT) && timer_expired && !press;
  assign timer_run = (next_state == S_WAIT);
  assign timer_clr = press || ((next_state == S_WAIT) && (state != S_WAIT));

  simon_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // State, round and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      round     <= '0;
      start_q   <= 1'b0;
      gen_en    <= 1'b0;
      disp_en   <= 1'b0;
      wait_en   <= 1'b0;
      chk_en    <= 1'b0;
      stage_clr <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      phase     <= PH_IDLE;
    end else begin
      state     <= next_state;
      round     <= next_round;
      start_q   <= start;
      gen_en    <= nxt_gen_en;
      disp_en   <= nxt_disp_en;
      wait_en   <= nxt_wait_en;
      chk_en    <= nxt_chk_en;
      stage_clr <= nxt_stage_clr;
      win       <= nxt_win;
      lose      <= nxt_lose;
      phase     <= nxt_phase;
    end
  end

  // Next state and round: abort, then the current stage's done, then
  // timeout, then a start edge. A done is only looked at in its own state.
  always_comb begin
    // NOTE: defaults before any branch keep this block free of latches.
    next_state = state;
    next_round = round;
    if (abort) begin
      next_state = S_IDLE;
      next_round = '0;
    end else begin
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start_rise) begin
            next_state = S_GEN;
            next_round = '0;
          end
        end
        S_GEN:  if (gen_done)  next_state = S_DISP;
        S_DISP: if (disp_done) next_state = S_WAIT;
        S_WAIT: begin
          if (wait_done)    next_state = S_CHK;
          else if (timeout) next_state = S_LOSE;
        end
        S_CHK: begin
          if (chk_done) begin
            if (!chk_pass) begin
              next_state = S_LOSE;
            end else if (round == ROUND_W'(MAX_ROUNDS - 1)) begin
              next_state = S_WIN;
            end else begin
              next_state = S_DISP;
              next_round = round + 1'b1;
            end
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Output decode of the next state; stage_clr marks entry into a stage.
  always_comb begin
    nxt_gen_en    = (next_state == S_GEN);
    nxt_disp_en   = (next_state == S_DISP);
    nxt_wait_en   = (next_state == S_WAIT);
    nxt_chk_en    = (next_state == S_CHK);
    nxt_win       = (next_state == S_WIN);
    nxt_lose      = (next_state == S_LOSE);
    nxt_phase     = phase_of(next_state);
    nxt_stage_clr = (next_state != state) &&
                    ((next_state == S_GEN) || (next_state == S_DISP) ||
                     (next_state == S_WAIT));
  end

endmodule

// File: tb/tb_simon_round_controller.sv
// Directed bench for simon_round_controller with 4 rounds and a
// 10-cycle timeout. Inputs change 1 ns after a rising edge; outputs are
// read at that same point, reflecting the edge just taken.
module tb_simon_round_controller;
  import simon_pkg::*;

  localparam int MAX_ROUNDS     = 4;
  localparam int ROUND_W        = 2;
  localparam int TIMEOUT_CYCLES = 10;
  localparam int TIMER_W        = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, abort, press;
  logic               gen_en, gen_done, disp_en, disp_done;
  logic               wait_en, wait_done, chk_en, chk_done, chk_pass;
  logic               stage_clr, win, lose;
  logic [ROUND_W-1:0] round;
  logic [1:0]         phase;

  int checks = 0;
  int passed = 0;
  int gen_visits = 0;

  simon_round_controller #(
    .MAX_ROUNDS     (MAX_ROUNDS),
    .ROUND_W        (ROUND_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .press     (press),
    .gen_en    (gen_en),
    .gen_done  (gen_done),
    .disp_en   (disp_en),
    .disp_done (disp_done),
    .wait_en   (wait_en),
    .wait_done (wait_done),
    .chk_en    (chk_en),
    .chk_done  (chk_done),
    .chk_pass  (chk_pass),
    .stage_clr (stage_clr),
    .round     (round),
    .win       (win),
    .lose      (lose),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  // Count GEN entries (enable together with the entry pulse).
  always @(negedge clk) if (gen_en && stage_clr) gen_visits++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Idle outputs: no enables, no clear, phase 00.
  task automatic check_quiet(input string tag);
    check({tag, " en"}, {gen_en, disp_en, wait_en, chk_en, stage_clr}, 5'b0);
    check({tag, " phase"}, phase, PH_IDLE);
  endtask

  task automatic start_game();
    start = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0;
  endtask

  // From IDLE/WIN/LOSE to the first cycle of WAIT in round 0.
  task automatic enter_wait();
    start_game();
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    disp_done = 1'b1; tick(); disp_done = 1'b0;
  endtask

  // Pass one full round starting in DISPLAY.
  task automatic pass_round();
    disp_done = 1'b1; tick(); disp_done = 1'b0;
    wait_done = 1'b1; tick(); wait_done = 1'b0;
    chk_pass = 1'b1; chk_done = 1'b1; tick(); chk_done = 1'b0; chk_pass = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; press = 1'b0;
    gen_done = 1'b0; disp_done = 1'b0; wait_done = 1'b0;
    chk_done = 1'b0; chk_pass = 1'b0;
    #12;
    check_quiet("reset");
    check("reset round", round, 0);
    check("reset win/lose", {win, lose}, 2'b00);
    rst_n = 1'b1;
    tick();

    // Start edge -> GEN with clear pulse, then DISPLAY.
    gen_visits = 0;
    start = 1'b1; tick();
    check("start gen_en", gen_en, 1);
    check("start stage_clr", stage_clr, 1);
    check("start round", round, 0);
    tick();
    check("gen hold", {gen_en, stage_clr}, 2'b10);
    start = 1'b0;
    disp_done = 1'b1; tick(); disp_done = 1'b0;
    check("disp_done ignored in GEN", {gen_en, disp_en}, 2'b10);
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    check("disp after gen", {gen_en, disp_en, stage_clr}, 3'b011);
    check("disp phase", phase, PH_DISP);

    // Four passing rounds to WIN.
    for (int r = 0; r < MAX_ROUNDS; r++) begin
      check($sformatf("round %0d index", r), round, r);
      disp_done = 1'b1; tick(); disp_done = 1'b0;
      check($sformatf("round %0d wait", r), {disp_en, wait_en, stage_clr}, 3'b011);
      check($sformatf("round %0d wait phase", r), phase, PH_WAIT);
      wait_done = 1'b1; tick(); wait_done = 1'b0;
      check($sformatf("round %0d chk", r), {wait_en, chk_en, stage_clr}, 3'b010);
      check($sformatf("round %0d chk phase", r), phase, PH_CHK);
      chk_pass = 1'b1; chk_done = 1'b1; tick(); chk_done = 1'b0; chk_pass = 1'b0;
      if (r < MAX_ROUNDS - 1) begin
        check($sformatf("round %0d next disp", r), {chk_en, disp_en, stage_clr}, 3'b011);
      end
    end
    check("win flag", {win, lose}, 2'b10);
    check_quiet("win");
    check("win round", round, 3);
    check("gen once", gen_visits, 1);
    tick();
    check("win held", win, 1);

    // Restart from WIN, fail in round 2 with start held high.
    start = 1'b1; tick();
    check("restart from win", {gen_en, win}, 2'b10);
    check("restart round", round, 0);
    start = 1'b0;
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    pass_round();
    pass_round();
    check("fail round index", round, 2);
    disp_done = 1'b1; tick(); disp_done = 1'b0;
    wait_done = 1'b1; tick(); wait_done = 1'b0;
    start = 1'b1;
    chk_pass = 1'b0; chk_done = 1'b1; tick(); chk_done = 1'b0;
    check("lose flag", {win, lose}, 2'b01);
    check("lose round", round, 2);
    check_quiet("lose");
    ticks(3);
    check("held start no restart", {lose, gen_en}, 2'b10);
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("re-press restart", {gen_en, stage_clr, lose}, 3'b110);
    check("re-press round", round, 0);
    start = 1'b0;

    // Timeout with no press: LOSE exactly 10 cycles after WAIT entry.
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    disp_done = 1'b1; tick(); disp_done = 1'b0;
    ticks(TIMEOUT_CYCLES - 1);
    check("timeout not yet", {wait_en, lose}, 2'b10);
    tick();
    check("timeout lose", {wait_en, lose}, 2'b01);

    // Press sampled at cycle 8 pushes LOSE to cycle 18.
    enter_wait();
    ticks(7);
    press = 1'b1; tick(); press = 1'b0;
    ticks(9);
    check("press delay not yet", {wait_en, lose}, 2'b10);
    tick();
    check("press delay lose", {wait_en, lose}, 2'b01);

    // Press in the expiry cycle clears the timer; later wait_done in the
    // expiry cycle wins over the timeout.
    enter_wait();
    ticks(TIMEOUT_CYCLES - 1);
    press = 1'b1; tick(); press = 1'b0;
    check("press at expiry", {wait_en, lose}, 2'b10);
    ticks(TIMEOUT_CYCLES - 1);
    wait_done = 1'b1; tick(); wait_done = 1'b0;
    check("wait_done at expiry", {chk_en, lose}, 2'b10);

    // Abort beats wait_done.
    chk_pass = 1'b1; chk_done = 1'b1; tick(); chk_done = 1'b0; chk_pass = 1'b0;
    disp_done = 1'b1; tick(); disp_done = 1'b0;
    check("abort setup", {wait_en, round}, 3'b101);
    abort = 1'b1; wait_done = 1'b1; tick(); abort = 1'b0; wait_done = 1'b0;
    check_quiet("abort");
    check("abort round/flags", {round, win, lose}, 4'b0);

    // Asynchronous reset in DISPLAY.
    start_game();
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    check("pre-reset disp", disp_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("async reset");
    check("async reset round/flags", {round, win, lose}, 4'b0);
    #10 rst_n = 1'b1;
    tick();
    check_quiet("after reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
